// File: rtl/periph_bus_demux_n.sv
// N-target demultiplexer for the peripheral req/gnt/r_valid bus.
// A small ordered tracking FIFO routes responses back, and unmapped requests get a local error reply.
module periph_bus_demux_n #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 10,
  parameter int NB_TARGETS      = 4,
  parameter int SEL_LSB         = 20,
  parameter int SEL_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst_ni,
  input  logic                             data_req_i,
  input  logic [ADDR_WIDTH-1:0]            data_add_i,
  input  logic                             data_wen_i,
  input  logic [DATA_WIDTH-1:0]            data_wdata_i,
  input  logic [BE_WIDTH-1:0]              data_be_i,
  input  logic [ID_WIDTH-1:0]              data_ID_i,
  output logic                             data_gnt_o,
  output logic                             data_r_valid_o,
  output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
  output logic                             data_r_opc_o,
  output logic [ID_WIDTH-1:0]              data_r_ID_o,
  output logic [NB_TARGETS-1:0]            tgt_req_o,
  output logic [NB_TARGETS*ADDR_WIDTH-1:0] tgt_add_o,
  output logic [NB_TARGETS-1:0]            tgt_wen_o,
  output logic [NB_TARGETS*DATA_WIDTH-1:0] tgt_wdata_o,
  output logic [NB_TARGETS*BE_WIDTH-1:0]   tgt_be_o,
  input  logic [NB_TARGETS-1:0]            tgt_gnt_i,
  input  logic [NB_TARGETS-1:0]            tgt_r_valid_i,
  input  logic [NB_TARGETS*DATA_WIDTH-1:0] tgt_r_rdata_i
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);

  if (NB_TARGETS < 1 || NB_TARGETS > (2 ** SEL_WIDTH) || MAX_OUTSTANDING < 1) begin : g_param_check
    $error("periph_bus_demux_n: illegal NB_TARGETS/SEL_WIDTH/MAX_OUTSTANDING combination");
  end

  logic [SEL_WIDTH-1:0] sel;
  logic                 mapped;
  logic                 empty;
  logic                 full;
  logic                 accept;
  logic                 push;
  logic                 pop;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] last_tgt_q, last_tgt_d;
  logic                 last_err_q, last_err_d;

  logic [SEL_WIDTH-1:0] fifo_tgt_q [MAX_OUTSTANDING];
  logic [SEL_WIDTH-1:0] fifo_tgt_d [MAX_OUTSTANDING];
  logic                 fifo_err_q [MAX_OUTSTANDING];
  logic                 fifo_err_d [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]  fifo_id_q  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]  fifo_id_d  [MAX_OUTSTANDING];

  logic [SEL_WIDTH-1:0] head_tgt;
  logic                 head_err;
  logic [ID_WIDTH-1:0]  head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Only a request to the same target with the same mapped/unmapped kind may overlap in-flight ones.
  always_comb begin
    sel    = data_add_i[SEL_LSB +: SEL_WIDTH];
    mapped = 1'b0;
    for (int t = 0; t < NB_TARGETS; t++) begin
      if (sel == SEL_WIDTH'(t)) mapped = 1'b1;
    end
    empty  = (cnt_q == '0);
    full   = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    accept = rst_ni && data_req_i && !full &&
             (empty || ((sel == last_tgt_q) && (last_err_q == !mapped)));

    tgt_req_o  = '0;
    data_gnt_o = 1'b0;
    if (accept) begin
      if (mapped) begin
        for (int t = 0; t < NB_TARGETS; t++) begin
          if (sel == SEL_WIDTH'(t)) begin
            tgt_req_o[t] = 1'b1;
            data_gnt_o   = tgt_gnt_i[t];
          end
        end
      end else begin
        data_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    tgt_add_o   = '0;
    tgt_wen_o   = '0;
    tgt_wdata_o = '0;
    tgt_be_o    = '0;
    if (rst_ni) begin
      for (int t = 0; t < NB_TARGETS; t++) begin
        tgt_add_o[t*ADDR_WIDTH +: ADDR_WIDTH]   = data_add_i;
        tgt_wen_o[t]                            = data_wen_i;
        tgt_wdata_o[t*DATA_WIDTH +: DATA_WIDTH] = data_wdata_i;
        tgt_be_o[t*BE_WIDTH +: BE_WIDTH]        = data_be_i;
      end
    end
  end

  // Responses only ever come from the head entry, so anything else on tgt_r_valid_i is dropped.
  always_comb begin
    head_tgt       = fifo_tgt_q[rd_ptr_q];
    head_err       = fifo_err_q[rd_ptr_q];
    head_id        = fifo_id_q[rd_ptr_q];
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    data_r_ID_o    = '0;
    if (!empty) begin
      data_r_ID_o = head_id;
      if (head_err) begin
        data_r_valid_o = 1'b1;
        data_r_rdata_o = ERR_RDATA;
        data_r_opc_o   = 1'b1;
      end else begin
        for (int t = 0; t < NB_TARGETS; t++) begin
          if (head_tgt == SEL_WIDTH'(t)) begin
            data_r_valid_o = tgt_r_valid_i[t];
            data_r_rdata_o = tgt_r_rdata_i[t*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  assign push = data_gnt_o;
  assign pop  = data_r_valid_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    last_tgt_d = last_tgt_q;
    last_err_d = last_err_q;
    fifo_tgt_d = fifo_tgt_q;
    fifo_err_d = fifo_err_q;
    fifo_id_d  = fifo_id_q;
    if (push) begin
      fifo_tgt_d[wr_ptr_q] = sel;
      fifo_err_d[wr_ptr_q] = !mapped;
      fifo_id_d[wr_ptr_q]  = data_ID_i;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
      last_tgt_d           = sel;
      last_err_d           = !mapped;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_tgt_q <= '0;
      last_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_tgt_q[i] <= '0;
        fifo_err_q[i] <= 1'b0;
        fifo_id_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_tgt_q <= last_tgt_d;
      last_err_q <= last_err_d;
      fifo_tgt_q <= fifo_tgt_d;
      fifo_err_q <= fifo_err_d;
      fifo_id_q  <= fifo_id_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_demux_n.sv
// Self-checking bench for periph_bus_demux_n: a 4-target instance for routing/ordering/reset
// and a 3-target instance for the unmapped error path, with a queue of expected responses.
module tb_periph_bus_demux_n;

  typedef struct packed {
    logic [31:0] rdata;
    logic        opc;
    logic [9:0]  id;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Master-side stimulus, shared address/data by both instances
  logic         m_req, b_req;
  logic [31:0]  m_add;
  logic         m_wen;
  logic [31:0]  m_wdata;
  logic [3:0]   m_be;
  logic [9:0]   m_id;

  // Instance A: 4 targets
  logic         gnt, rvalid, opc;
  logic [31:0]  rdata;
  logic [9:0]   rid;
  logic [3:0]   treq, twen, tgnt, trv;
  logic [127:0] tadd, twdata, trdata;
  logic [15:0]  tbe;

  // Instance B: 3 targets, sel=3 unmapped
  logic         b_gnt, b_rvalid, b_opc;
  logic [31:0]  b_rdata;
  logic [9:0]   b_rid;
  logic [2:0]   b_treq, b_twen, b_tgnt, b_trv;
  logic [95:0]  b_tadd, b_twdata, b_trdata;
  logic [11:0]  b_tbe;

  periph_bus_demux_n dut (
    .clk(clk), .rst_ni(rst_n),
    .data_req_i(m_req), .data_add_i(m_add), .data_wen_i(m_wen), .data_wdata_i(m_wdata),
    .data_be_i(m_be), .data_ID_i(m_id),
    .data_gnt_o(gnt), .data_r_valid_o(rvalid), .data_r_rdata_o(rdata),
    .data_r_opc_o(opc), .data_r_ID_o(rid),
    .tgt_req_o(treq), .tgt_add_o(tadd), .tgt_wen_o(twen), .tgt_wdata_o(twdata), .tgt_be_o(tbe),
    .tgt_gnt_i(tgnt), .tgt_r_valid_i(trv), .tgt_r_rdata_i(trdata)
  );

  periph_bus_demux_n #(.NB_TARGETS(3)) dut_b (
    .clk(clk), .rst_ni(rst_n),
    .data_req_i(b_req), .data_add_i(m_add), .data_wen_i(m_wen), .data_wdata_i(m_wdata),
    .data_be_i(m_be), .data_ID_i(m_id),
    .data_gnt_o(b_gnt), .data_r_valid_o(b_rvalid), .data_r_rdata_o(b_rdata),
    .data_r_opc_o(b_opc), .data_r_ID_o(b_rid),
    .tgt_req_o(b_treq), .tgt_add_o(b_tadd), .tgt_wen_o(b_twen), .tgt_wdata_o(b_twdata), .tgt_be_o(b_tbe),
    .tgt_gnt_i(b_tgnt), .tgt_r_valid_i(b_trv), .tgt_r_rdata_i(b_trdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = 1'b0; b_req = 1'b0;
    tgnt = '0; trv = '0; trdata = '0;
    b_tgnt = '0; b_trv = '0; b_trdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    m_add = 32'h0010_0000; m_wen = 1'b1; m_wdata = 32'h0; m_be = 4'hF; m_id = 10'h0;
    m_req = 1'b1; tgnt = 4'hF; b_req = 1'b1; b_tgnt = 3'h7;
    #4;
    checks++; if (gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt got %b want 0", gnt); end
    checks++; if (treq !== 4'h0) begin errors++; $display("[TB] FAIL rst_treq got %b want 0000", treq); end
    checks++; if ({rvalid, rdata, opc, rid} !== '0) begin
      errors++; $display("[TB] FAIL rst_resp got %b/%h/%b/%h want all 0", rvalid, rdata, opc, rid);
    end
    checks++; if (tadd !== '0) begin errors++; $display("[TB] FAIL rst_tadd got %h want 0", tadd); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_gnt got %b want 0", b_gnt); end
    next_cycle();
    next_cycle();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    next_cycle();
    m_req = 1'b1; m_add = 32'h1A10_0000; m_wen = 1'b1; m_id = 10'h02A; tgnt = 4'b0010;
    sbq.push_back(exp_t'{32'h1234_5678, 1'b0, 10'h02A});
    #3;
    checks++; if (treq !== 4'b0010) begin errors++; $display("[TB] FAIL single_treq got %b want 0010", treq); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL single_gnt got %b want 1", gnt); end
    checks++; if ({tadd[32 +: 32], twen} !== {32'h1A10_0000, 4'hF}) begin
      errors++; $display("[TB] FAIL single_bcast got %h/%b want 1a100000/1111", tadd[32 +: 32], twen);
    end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_rvalid got %b want 0", rvalid); end
    next_cycle();
    m_req = 1'b0; tgnt = '0; trv = 4'b0010; trdata[32 +: 32] = 32'h1234_5678;
    #3;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_rvalid got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL single_sb response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL single_resp got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = '0;
    #3;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_after got %b want 0", rvalid); end
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL single_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    m_req = 1'b1; m_add = 32'h0020_0000; m_id = 10'd1; tgnt = 4'b0100;
    sbq.push_back(exp_t'{32'hC0DE_0001, 1'b0, 10'd1});
    #3;
    checks++; if ({gnt, treq} !== {1'b1, 4'b0100}) begin errors++; $display("[TB] FAIL b2b_g1 got %b/%b want 1/0100", gnt, treq); end
    next_cycle();
    m_id = 10'd2;
    sbq.push_back(exp_t'{32'hC0DE_0002, 1'b0, 10'd2});
    #3;
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_g2 got %b want 1", gnt); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rv_c1 got %b want 0", rvalid); end
    next_cycle();
    m_id = 10'd3;
    sbq.push_back(exp_t'{32'hC0DE_0003, 1'b0, 10'd3});
    #3;
    checks++; if ({gnt, treq} !== 5'b0) begin errors++; $display("[TB] FAIL b2b_full got %b/%b want 0/0000", gnt, treq); end
    for (int c = 3; c <= 4; c++) begin
      next_cycle();
      trv = 4'b0100; trdata[64 +: 32] = 32'hC0DE_0000 + 32'(c - 2);
      #3;
      checks++; if (gnt !== (c == 4)) begin errors++; $display("[TB] FAIL b2b_g3_c%0d got %b want %b", c, gnt, c == 4); end
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rvalid_c%0d got %b want 1", c, rvalid); end
      else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL b2b_sb response with empty queue"); end
      else begin
        e = sbq.pop_front();
        checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
          errors++; $display("[TB] FAIL b2b_resp got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
        end
      end
    end
    next_cycle();
    m_req = 1'b0; tgnt = '0; trv = '0;
    #3;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap got %b want 0", rvalid); end
    next_cycle();
    next_cycle();
    trv = 4'b0100; trdata[64 +: 32] = 32'hC0DE_0003;
    #3;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rvalid3 got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL b2b_sb3 response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL b2b_resp3 got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = '0;
    #1;
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL b2b_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_switch_target();
    next_cycle();
    m_req = 1'b1; m_add = 32'h0010_0000; m_id = 10'd5; tgnt = 4'b1010;
    sbq.push_back(exp_t'{32'h1111_0005, 1'b0, 10'd5});
    #3;
    checks++; if ({gnt, treq} !== {1'b1, 4'b0010}) begin errors++; $display("[TB] FAIL sw_g1 got %b/%b want 1/0010", gnt, treq); end
    next_cycle();
    m_add = 32'h0030_0000; m_id = 10'd6;
    sbq.push_back(exp_t'{32'h3333_0006, 1'b0, 10'd6});
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin trv = 4'b0010; trdata[32 +: 32] = 32'h1111_0005; end
      #3;
      checks++; if ({gnt, treq} !== 5'b0) begin errors++; $display("[TB] FAIL sw_stall_c%0d got %b/%b want 0/0000", c, gnt, treq); end
      if (c < 3) next_cycle();
    end
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL sw_rvalid1 got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL sw_sb1 response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL sw_resp1 got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = '0;
    #3;
    checks++; if ({gnt, treq} !== {1'b1, 4'b1000}) begin errors++; $display("[TB] FAIL sw_g2 got %b/%b want 1/1000", gnt, treq); end
    next_cycle();
    m_req = 1'b0; tgnt = '0;
    next_cycle();
    trv = 4'b1000; trdata[96 +: 32] = 32'h3333_0006;
    #3;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL sw_rvalid2 got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL sw_sb2 response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL sw_resp2 got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = '0;
    #1;
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL sw_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_spurious();
    next_cycle();
    m_req = 1'b1; m_add = 32'h0020_0000; m_id = 10'd7; tgnt = 4'b0100;
    sbq.push_back(exp_t'{32'h2222_0007, 1'b0, 10'd7});
    #3;
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL spur_gnt got %b want 1", gnt); end
    next_cycle();
    m_req = 1'b0; tgnt = '0; trv = 4'b0001; trdata[0 +: 32] = 32'hDEAD_BEEF;
    #3;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL spur_nonhead got %b want 0", rvalid); end
    next_cycle();
    trv = 4'b0100; trdata[64 +: 32] = 32'h2222_0007;
    #3;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL spur_rvalid got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL spur_sb response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL spur_resp got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = 4'b0001;
    #3;
    checks++; if ({rvalid, rdata, opc, rid} !== '0) begin
      errors++; $display("[TB] FAIL spur_empty got %b/%h/%b/%h want all 0", rvalid, rdata, opc, rid);
    end
    next_cycle();
    trv = '0;
    #1;
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL spur_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    m_req = 1'b1; m_add = 32'h0020_0000; m_id = 10'd8; tgnt = 4'b0100;
    #3;
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstf_g1 got %b want 1", gnt); end
    next_cycle();
    m_id = 10'd9;
    #3;
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstf_g2 got %b want 1", gnt); end
    next_cycle();
    rst_n = 1'b0; trv = 4'b0100; trdata[64 +: 32] = 32'h5555_5555;
    #3;
    checks++; if ({gnt, treq, rvalid, rdata, opc, rid} !== '0) begin
      errors++; $display("[TB] FAIL rstf_outs got %b/%b/%b/%h/%b/%h want all 0", gnt, treq, rvalid, rdata, opc, rid);
    end
    next_cycle();
    rst_n = 1'b1; m_req = 1'b0; tgnt = '0;
    #3;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstf_late got %b want 0", rvalid); end
    next_cycle();
    trv = '0; m_req = 1'b1; m_add = 32'h0000_0000; m_id = 10'h3FF; tgnt = 4'b0001;
    sbq.push_back(exp_t'{32'h6666_6666, 1'b0, 10'h3FF});
    #3;
    checks++; if ({gnt, treq} !== {1'b1, 4'b0001}) begin errors++; $display("[TB] FAIL rstf_post got %b/%b want 1/0001", gnt, treq); end
    next_cycle();
    m_req = 1'b0; tgnt = '0; trv = 4'b0001; trdata[0 +: 32] = 32'h6666_6666;
    #3;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rstf_rvalid got %b want 1", rvalid); end
    else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL rstf_sb response with empty queue"); end
    else begin
      e = sbq.pop_front();
      checks++; if ({rdata, opc, rid} !== {e.rdata, e.opc, e.id}) begin
        errors++; $display("[TB] FAIL rstf_resp got %h/%b/%h want %h/%b/%h", rdata, opc, rid, e.rdata, e.opc, e.id);
      end
    end
    next_cycle();
    trv = '0;
    #1;
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL rstf_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_unmapped();
    next_cycle();
    b_req = 1'b1; m_add = 32'h0030_0000; m_id = 10'h1C3; b_tgnt = 3'b111;
    sbq.push_back(exp_t'{32'hBADA_CCE5, 1'b1, 10'h1C3});
    #3;
    checks++; if ({b_gnt, b_treq} !== {1'b1, 3'b000}) begin errors++; $display("[TB] FAIL unm_g1 got %b/%b want 1/000", b_gnt, b_treq); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL unm_same_cycle got %b want 0", b_rvalid); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      if (c == 1) begin
        m_id = 10'h1C4;
        sbq.push_back(exp_t'{32'hBADA_CCE5, 1'b1, 10'h1C4});
      end else begin
        b_req = 1'b0;
      end
      #3;
      if (c == 1) begin
        checks++; if ({b_gnt, b_treq} !== {1'b1, 3'b000}) begin errors++; $display("[TB] FAIL unm_g2 got %b/%b want 1/000", b_gnt, b_treq); end
      end
      checks++;
      if (b_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL unm_rvalid_c%0d got %b want 1", c, b_rvalid); end
      else if (sbq.size() == 0) begin errors++; $display("[TB] FAIL unm_sb response with empty queue"); end
      else begin
        e = sbq.pop_front();
        checks++; if ({b_rdata, b_opc, b_rid} !== {e.rdata, e.opc, e.id}) begin
          errors++; $display("[TB] FAIL unm_resp got %h/%b/%h want %h/%b/%h", b_rdata, b_opc, b_rid, e.rdata, e.opc, e.id);
        end
      end
    end
    next_cycle();
    b_tgnt = '0;
    #3;
    checks++; if ({b_rvalid, b_opc, b_rdata} !== '0) begin
      errors++; $display("[TB] FAIL unm_after got %b/%b/%h want all 0", b_rvalid, b_opc, b_rdata);
    end
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL unm_left got %0d want 0", sbq.size()); end
    sbq.delete();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_read();
    test_back_to_back();
    test_switch_target();
    test_spurious();
    test_reset_inflight();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_demux_n.md
Name: periph_bus_demux_n

Overview:
- Parametrised N-target demultiplexer for the peripheral req/gnt/r_valid bus.
- Decodes one address field to select one of NB_TARGETS slaves, e.g. APB peripherals, eFPGA config and eFPGA HWCE windows.
- Supports up to MAX_OUTSTANDING in-flight transactions and returns responses to the master in order with the matching ID.
- Unmapped addresses get a locally generated error response.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ID_WIDTH, 10, transaction ID width.
- NB_TARGETS, 4, number of slave ports (1..2**SEL_WIDTH).
- SEL_LSB, 20, LSB of the address select field.
- SEL_WIDTH, 2, width of the select field.
- MAX_OUTSTANDING, 2, depth of the response-tracking FIFO (>=1).

Ports:
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  master request
- data_add_i  in  ADDR_WIDTH  master address
- data_wen_i  in  1  write enable, active low (1 = read)
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  request ID
- data_gnt_o  out  1  grant to master
- data_r_valid_o  out  1  response valid
- data_r_rdata_o  out  DATA_WIDTH  response data
- data_r_opc_o  out  1  response error flag (1 = unmapped)
- data_r_ID_o  out  ID_WIDTH  response ID
- tgt_req_o  out  NB_TARGETS  per-target request
- tgt_add_o  out  NB_TARGETS*ADDR_WIDTH  per-target address, broadcast
- tgt_wen_o  out  NB_TARGETS  per-target wen, broadcast
- tgt_wdata_o  out  NB_TARGETS*DATA_WIDTH  per-target write data, broadcast
- tgt_be_o  out  NB_TARGETS*BE_WIDTH  per-target byte enables, broadcast
- tgt_gnt_i  in  NB_TARGETS  per-target grant
- tgt_r_valid_i  in  NB_TARGETS  per-target response valid
- tgt_r_rdata_i  in  NB_TARGETS*DATA_WIDTH  per-target response data

Behaviour:
- Decode: sel = data_add_i[SEL_LSB +: SEL_WIDTH]. sel < NB_TARGETS selects a mapped target; otherwise the request is unmapped.
- Tracking FIFO: MAX_OUTSTANDING entries of {tgt index, err flag, ID}, with read/write pointers and an occupancy counter. Push on data_gnt_o; pop on data_r_valid_o. Simultaneous push and pop is allowed, and occupancy is unchanged.
- Accept condition: data_req_i=1, FIFO not full, and one of:
  - FIFO empty, or
  - sel equals the tgt index of the last pushed entry, and that entry's err flag matches the new request's unmapped state.
- Switching to a different target therefore stalls until the FIFO drains. Responses can never reorder.
- Mapped accept: tgt_req_o[sel] = 1 combinationally. data_gnt_o = tgt_gnt_i[sel] in the same cycle. All other tgt_req_o bits are 0.
- Unmapped accept: data_gnt_o = 1 in the same cycle. No tgt_req_o is asserted.
- When the accept condition fails: tgt_req_o = 0 and data_gnt_o = 0.
- Response, head entry mapped:
  - data_r_valid_o = tgt_r_valid_i[head.tgt].
  - data_r_rdata_o = tgt_r_rdata_i[head.tgt].
  - data_r_opc_o = 0.
- Response, head entry err: data_r_valid_o = 1 in any cycle the entry is at the head, which is at least 1 cycle after grant. data_r_rdata_o = 32'hBADACCE5 (zero-extended or truncated to DATA_WIDTH). data_r_opc_o = 1.
- data_r_ID_o = head.ID whenever the FIFO is not empty, else 0.
- FIFO empty: data_r_valid_o = 0, data_r_rdata_o = 0, data_r_opc_o = 0. Any tgt_r_valid_i from a non-head target, or received while empty, is ignored.
- Minimum latency: grant in cycle N, response no earlier than N+1. A response for a granted entry may coincide with a new grant.
- Reset (async assert): pointers, counter and all FIFO entries cleared. All outputs go to 0. Responses still in flight are dropped.
- Parameter check: an elaboration error is raised if NB_TARGETS > 2**SEL_WIDTH or MAX_OUTSTANDING < 1.

Test Plan:
- Read at addr 0x1A10_0000 (sel=1), tgt_gnt_i[1]=1, r_valid 1 cycle later with rdata 0x1234_5678 and ID 0x2A -> tgt_req_o=4'b0010, data_gnt_o=1 same cycle, then data_r_valid_o=1, rdata 0x1234_5678, r_ID 0x2A, opc 0.
- Back-to-back reads to target 2, with target responses delayed 3 cycles, MAX_OUTSTANDING=2 -> two grants, third request stalls (gnt=0) until the first response; responses return in order with IDs 1 and 2.
- Read to target 1 outstanding, then request to target 3 -> target 3 request not asserted and gnt=0 until target 1's response; target 3 granted in the cycle after the FIFO empties.
- With NB_TARGETS=3, request with sel=3 -> gnt=1, no tgt_req_o; next cycle r_valid=1, rdata 0xBADACCE5, opc=1, matching ID.
- Spurious tgt_r_valid_i[0] pulse while the head is target 2 or the FIFO is empty -> data_r_valid_o stays 0.
- rst_ni low while 2 transactions are outstanding -> all outputs 0 immediately; later target responses are ignored; first post-reset request is granted normally.
